// File: rtl/notch_sweep_ctrl.sv
// Purpose: sequences a frequency sweep over a shared notch engine: loads per-point
// Latency: coefficients, discards settling samples, averages |result| and reports per point.
// Backpressure: cfg/smp requests hold until their ready; only one sample is ever outstanding.
//
// Ports:
//   clk, rst            sole clock, synchronous active-high reset
//   start, abort        begin sweep (IDLE only) / terminate sweep (any busy state)
//   busy, done          sweep in progress / one-cycle completion pulse
//   cfg_valid/idx/ready coefficient-load request for point cfg_idx
//   smp_valid/ready     stimulus-sample request
//   res_valid/data      engine response, one per accepted sample (two's complement)
//   pt_valid/idx/mag    per-point averaged magnitude (unsigned)
//   min_mag/min_idx     smallest reported magnitude and its point; present only when
//                       NOTCH_SWEEP_MIN_EN is defined
module notch_sweep_ctrl #(
    parameter  int DW       = 16,
    parameter  int NPTS     = 16,
    parameter  int SETTLE   = 8,
    parameter  int AVG_LOG2 = 2,
    localparam int IW       = $clog2(NPTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          cfg_valid,
    output logic [IW-1:0] cfg_idx,
    input  logic          cfg_ready,
    output logic          smp_valid,
    input  logic          smp_ready,
    input  logic          res_valid,
    input  logic [DW-1:0] res_data,
    output logic          pt_valid,
    output logic [IW-1:0] pt_idx,
    output logic [DW-1:0] pt_mag
`ifdef NOTCH_SWEEP_MIN_EN
    ,
    output logic [DW-1:0] min_mag,
    output logic [IW-1:0] min_idx
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_MEAS, S_REPORT, S_DONE
    } state_t;

    localparam int            AW          = DW + AVG_LOG2;
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]    AVG_LAST    = 8'((1 << AVG_LOG2) - 1);
    localparam logic [IW-1:0] K_LAST      = IW'(NPTS - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] k_q, k_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          pend_q, pend_d;
    logic [IW-1:0] pt_idx_q, pt_idx_d;
    logic [DW-1:0] pt_mag_q, pt_mag_d;
    logic          busy_q, done_q, cfg_valid_q, smp_valid_q, pt_valid_q;

    logic          rsp;
    logic [DW-1:0] res_abs;

    // Unsigned magnitude in DW bits: the most negative value maps to 2^(DW-1) exactly.
    assign res_abs = res_data[DW-1] ? (~res_data + 1'b1) : res_data;
    // Responses with nothing pending (including any arriving in IDLE) are dropped here.
    assign rsp     = res_valid && pend_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        pt_idx_d = pt_idx_q;
        pt_mag_d = pt_mag_q;
        // smp_valid is only raised with nothing pending, so set and clear never coincide.
        pend_d   = pend_q ? !res_valid : (smp_valid_q && smp_ready);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    k_d     = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cfg_valid_q && cfg_ready) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (SETTLE == 0) ? S_MEAS : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (rsp) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = S_MEAS;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_MEAS: begin
                if (rsp) begin
                    acc_d = acc_q + AW'(res_abs);
                    if (cnt_q == AVG_LAST) begin
                        state_d  = S_REPORT;
                        pt_idx_d = k_q;
                        pt_mag_d = DW'(acc_d >> AVG_LOG2);
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_REPORT: begin
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything in a busy state; the point being measured is not reported.
        if (state_q != S_IDLE && abort) begin
            state_d  = S_IDLE;
            pend_d   = 1'b0;
            pt_idx_d = pt_idx_q;
            pt_mag_d = pt_mag_q;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            pend_q      <= 1'b0;
            pt_idx_q    <= '0;
            pt_mag_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            smp_valid_q <= 1'b0;
            pt_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            pend_q      <= pend_d;
            pt_idx_q    <= pt_idx_d;
            pt_mag_q    <= pt_mag_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            cfg_valid_q <= (state_d == S_LOAD);
            smp_valid_q <= (state_d == S_SETTLE || state_d == S_MEAS) && !pend_d;
            pt_valid_q  <= (state_d == S_REPORT);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_idx   = k_q;
    assign smp_valid = smp_valid_q;
    assign pt_valid  = pt_valid_q;
    assign pt_idx    = pt_idx_q;
    assign pt_mag    = pt_mag_q;

`ifdef NOTCH_SWEEP_MIN_EN
    logic [DW-1:0] min_mag_q;
    logic [IW-1:0] min_idx_q;

    // pt_valid_q is high exactly while in REPORT; strict compare keeps the first minimum.
    always_ff @(posedge clk) begin
        if (rst || (state_q == S_IDLE && start && !abort)) begin
            min_mag_q <= '1;
            min_idx_q <= '0;
        end else if (pt_valid_q && (pt_mag_q < min_mag_q)) begin
            min_mag_q <= pt_mag_q;
            min_idx_q <= pt_idx_q;
        end
    end

    assign min_mag = min_mag_q;
    assign min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_notch_sweep_ctrl.sv
// Purpose: randomized self-checking bench; the bench plays the notch engine and predicts
// Latency: each point's magnitude from the raw response stream (settle, then average).
// Backpressure: ready signals are either held high, randomized, or stalled on purpose.
module tb_notch_sweep_ctrl;

    localparam int DW       = 16;
    localparam int NPTS     = 4;
    localparam int SETTLE   = 2;
    localparam int AVG_LOG2 = 2;
    localparam int IW       = 2;
    localparam int NAVG     = 1 << AVG_LOG2;
    localparam int PER      = SETTLE + NAVG;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_ready = 1'b0;
    logic          smp_ready = 1'b0;
    logic          res_valid = 1'b0;
    logic [DW-1:0] res_data = '0;
    logic          busy, done, cfg_valid, smp_valid, pt_valid;
    logic [IW-1:0] cfg_idx, pt_idx;
    logic [DW-1:0] pt_mag;
`ifdef NOTCH_SWEEP_MIN_EN
    logic [DW-1:0] min_mag;
    logic [IW-1:0] min_idx;
`endif

    notch_sweep_ctrl #(
        .DW(DW), .NPTS(NPTS), .SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_ready(cfg_ready),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .res_valid(res_valid), .res_data(res_data),
        .pt_valid(pt_valid), .pt_idx(pt_idx), .pt_mag(pt_mag)
`ifdef NOTCH_SWEEP_MIN_EN
        , .min_mag(min_mag), .min_idx(min_idx)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Engine / reference model state.
    int data_mode  = 0;   // 0 random, 1 +/-100, 2 most negative, 3 per-point table
    int rdy_mode   = 0;   // 0 ready high, 1 random ready, 2 cfg_ready stalled
    int force_dly  = -1;  // response delay override (-1: random 0..3)
    bit eng_pend   = 0;
    int eng_dly    = 0;
    bit stale      = 0;   // next delivered response belongs to an aborted/reset sweep
    bit start_noise = 0;
    int resp_n, pts_seen, dones_seen, smp_cnt;
    int pv_cnt = 0;
    int acc_m [NPTS];
    int mag_tab [NPTS] = '{50, 10, 10, 40};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int absv(input logic [DW-1:0] d);
        int v;
        v = int'($signed(d));
        return (v < 0) ? -v : v;
    endfunction

    task automatic reset_model();
        resp_n = 0; pts_seen = 0; dones_seen = 0; smp_cnt = 0;
        for (int i = 0; i < NPTS; i++) acc_m[i] = 0;
    endtask

    // Response n of a sweep belongs to point n/PER; its first SETTLE are discarded.
    task automatic drive_response();
        int pt;
        pt = resp_n / PER;
        case (data_mode)
            1:       res_data = (resp_n % 2 == 0) ? 16'd100 : 16'hFF9C;
            2:       res_data = 16'h8000;
            3:       res_data = DW'(mag_tab[pt % NPTS]);
            default: res_data = DW'($urandom);
        endcase
        res_valid = 1'b1;
        if (stale) begin
            stale = 1'b0;
        end else begin
            if ((resp_n % PER) >= SETTLE && pt < NPTS) acc_m[pt] += absv(res_data);
            resp_n++;
        end
    endtask

    task automatic step();
        bit hs;
        hs = smp_valid && smp_ready;
        @(posedge clk);
        #1;
        if (hs) begin
            check_val("one_outstanding", eng_pend, 0);
            eng_pend = 1'b1;
            eng_dly  = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
            smp_cnt++;
        end
        if (pt_valid) begin
            check_val("pt_idx", pt_idx, pts_seen % NPTS);
            check_val("pt_mag", pt_mag, acc_m[pts_seen % NPTS] / NAVG);
            pts_seen++;
            pv_cnt++;
        end
        if (done) begin
            check_val("done_after_last_pt", pts_seen, NPTS);
            dones_seen++;
        end
        res_valid = 1'b0;
        if (eng_pend) begin
            if (eng_dly == 0) begin
                eng_pend = 1'b0;
                drive_response();
            end else begin
                eng_dly--;
            end
        end
        smp_ready = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        cfg_ready = (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) :
                    ((rdy_mode == 2) ? 1'b0 : 1'b1);
        if (start_noise) start = busy && !done && ($urandom_range(0, 7) == 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_cfg_valid"}, cfg_valid, 0);
        check_val({tag, "_smp_valid"}, smp_valid, 0);
        check_val({tag, "_pt_valid"}, pt_valid, 0);
        check_val({tag, "_cfg_idx"}, cfg_idx, 0);
        check_val({tag, "_pt_idx"}, pt_idx, 0);
        check_val({tag, "_pt_mag"}, pt_mag, 0);
    endtask

    task automatic run_sweep(input int dm, input int rm, input bit noise, input bit stall);
        int guard;
        data_mode = dm;
        rdy_mode  = rm;
        reset_model();
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("cfg_idx_first", cfg_idx, 0);
        if (stall) begin
            rdy_mode  = 2;
            cfg_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                check_val("stall_cfg_valid", cfg_valid, 1);
                check_val("stall_cfg_idx", cfg_idx, 0);
                check_val("stall_no_sample", smp_valid, 0);
            end
            rdy_mode = rm;
        end
        start_noise = noise;
        guard = 0;
        while (dones_seen == 0 && guard < 3000) begin
            step();
            guard++;
        end
        start_noise = 1'b0;
        start = 1'b0;
        check_val("sweep_finished", dones_seen, 1);
        check_val("points_reported", pts_seen, NPTS);
        step();
        step();
        check_val("idle_after_done", busy, 0);
        check_val("single_done", dones_seen, 1);
    endtask

    initial begin
        int guard;
        int pv_before;
        int bad_io;

        reset_model();
        rst = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
`ifdef NOTCH_SWEEP_MIN_EN
        check_val("reset_min_mag", min_mag, 16'hFFFF);
        check_val("reset_min_idx", min_idx, 0);
`endif
        rst = 1'b0;
        step();

        run_sweep(1, 0, 1'b0, 1'b0);   // +100/-100, ready always high
        run_sweep(2, 0, 1'b0, 1'b0);   // most negative input, no overflow
        run_sweep(0, 1, 1'b0, 1'b0);   // random data and ready
        run_sweep(0, 1, 1'b1, 1'b0);   // start pulses while busy
        run_sweep(0, 0, 1'b0, 1'b1);   // cfg_ready stall in LOAD

        // start together with abort in IDLE must not start a sweep
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_val("start_abort_busy", busy, 0);
        check_val("start_abort_cfg", cfg_valid, 0);
        step();
        check_val("start_abort_busy2", busy, 0);

        // abort during MEAS of point 1 with a response outstanding
        data_mode = 0;
        rdy_mode  = 0;
        force_dly = 3;
        reset_model();
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (smp_cnt < PER + SETTLE + 1 && guard < 1000) begin
            step();
            guard++;
        end
        check_val("reached_meas_pt1", smp_cnt, PER + SETTLE + 1);
        check_val("pt0_before_abort", pts_seen, 1);
        stale = eng_pend;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("busy_after_abort", busy, 0);
        pv_before = pv_cnt;
        bad_io = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (smp_valid || cfg_valid || busy) bad_io++;
        end
        check_val("no_pt_after_abort", pv_cnt, pv_before);
        check_val("no_done_after_abort", dones_seen, 0);
        check_val("quiet_after_abort", bad_io, 0);
        force_dly = -1;
        run_sweep(0, 1, 1'b0, 1'b0);   // restarts from point 0

        // reset during SETTLE of point 0
        data_mode = 0;
        rdy_mode  = 0;
        force_dly = 2;
        reset_model();
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (smp_cnt < 1 && guard < 1000) begin
            step();
            guard++;
        end
        check_val("reached_settle", smp_cnt, 1);
        stale = eng_pend;
        rst = 1'b1;
        step();
        check_all_zero("rst_settle");
        rst = 1'b0;
        repeat (8) step();
        force_dly = -1;
        check_val("idle_after_rst", busy, 0);

`ifdef NOTCH_SWEEP_MIN_EN
        run_sweep(3, 1, 1'b0, 1'b0);
        check_val("min_mag", min_mag, 10);
        check_val("min_idx", min_idx, 1);
`else
        run_sweep(3, 1, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/notch_sweep_ctrl.md
NOTCH_SWEEP_CTRL -- requirements
Module: notch_sweep_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16: engine result width, two's-complement.
REQ-002 SHALL have parameter NPTS, default 16: sweep points; legal range 2..256.
REQ-003 SHALL have parameter SETTLE, default 8: discarded settling samples per point; legal range 0..255.
REQ-004 SHALL have parameter AVG_LOG2, default 2: averaged samples per point = 2^AVG_LOG2; legal range 0..4.
REQ-005 SHALL derive IW = $clog2(NPTS).
REQ-006 SHALL have port clk  in  1: sole clock, all logic on its rising edge.
REQ-007 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-008 SHALL have port start  in  1: begin sweep; sampled only in IDLE.
REQ-009 SHALL have port abort  in  1: terminate sweep.
REQ-010 SHALL have port busy  out  1: high in every state except IDLE.
REQ-011 SHALL have port done  out  1: one-cycle pulse when a sweep completes.
REQ-012 SHALL have ports cfg_valid out 1, cfg_idx out IW, cfg_ready in 1: coefficient-load request for the shared notch engine.
REQ-013 SHALL have ports smp_valid out 1, smp_ready in 1: stimulus-sample request to the engine.
REQ-014 SHALL have ports res_valid in 1, res_data in DW: engine response, one per accepted sample.
REQ-015 SHALL have ports pt_valid out 1, pt_idx out IW, pt_mag out DW: per-point averaged magnitude, unsigned.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, SETTLE, MEAS, REPORT and DONE.
REQ-017 SHALL, in IDLE with start=1 and abort=0, clear point index k to 0 and enter LOAD next cycle.
REQ-018 SHALL, in LOAD, hold cfg_valid=1 and cfg_idx=k; on cfg_valid&&cfg_ready, enter SETTLE, or MEAS if SETTLE=0.
REQ-019 SHALL keep at most one sample outstanding: smp_valid=1 only when no response is pending; smp_valid&&smp_ready marks a sample pending; res_valid clears it.
REQ-020 SHALL drop res_valid that arrives with no sample pending, or while in IDLE.
REQ-021 SHALL, in SETTLE, discard exactly SETTLE responses, then enter MEAS with the accumulator cleared.
REQ-022 SHALL, in MEAS, add |res_data| to a (DW+AVG_LOG2)-bit accumulator per response; |-2^(DW-1)| = 2^(DW-1), no saturation.
REQ-023 SHALL, after 2^AVG_LOG2 responses, enter REPORT.
REQ-024 SHALL, in REPORT, assert pt_valid for exactly one cycle, with pt_idx=k and pt_mag=acc>>AVG_LOG2 (truncating).
REQ-025 SHALL, on leaving REPORT, go to DONE if k==NPTS-1; otherwise increment k and go to LOAD.
REQ-026 SHALL, in DONE, assert done for one cycle, then return to IDLE.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle with no pt_valid or done; an outstanding response is later dropped per REQ-020.
REQ-029 SHALL give abort priority over start when both are high in the same IDLE cycle; the sweep does not start.
REQ-030 SHALL register every output; cfg_valid and smp_valid SHALL not drop before their handshake completes, except on abort or rst.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, enter IDLE and clear k, the accumulator, all counters and the pending flag.
REQ-032 SHALL drive busy, done, cfg_valid, smp_valid and pt_valid to 0, and cfg_idx, pt_idx and pt_mag to 0, from reset.
REQ-033 SHALL give rst priority over every other input, including mid-sweep and mid-handshake.

Configuration
REQ-034 SHALL, with NOTCH_SWEEP_MIN_EN defined, add outputs min_mag (DW) and min_idx (IW).
REQ-035 With NOTCH_SWEEP_MIN_EN defined, min_mag and min_idx SHALL be set to all-ones and 0 on sweep start and on reset.
REQ-036 With NOTCH_SWEEP_MIN_EN defined, min_mag and min_idx SHALL update in REPORT when pt_mag < min_mag (strict, so the first minimum wins).
REQ-037 SHALL, without NOTCH_SWEEP_MIN_EN, omit those ports and that logic entirely.

Verification
REQ-038 SHALL check: NPTS=4, SETTLE=2, AVG_LOG2=2, ready always 1, res_data = +100,-100,+100,-100... -> four pt_valid pulses, pt_idx 0..3, pt_mag=100; one done after pt_idx=3.
REQ-039 SHALL check: res_data=-32768 (DW=16) for all samples -> pt_mag=32768 with no overflow.
REQ-040 SHALL check: cfg_ready held 0 for 10 cycles in LOAD -> cfg_valid stays high with stable cfg_idx, no sample issued; the sweep resumes on cfg_ready=1.
REQ-041 SHALL check: abort in MEAS of point 1 -> busy=0 next cycle, no further pt_valid, no done; a late res_valid is ignored; a new start runs from k=0.
REQ-042 SHALL check: start pulsed mid-sweep, and start together with abort in IDLE -> no effect on the sweep; rst during SETTLE -> all outputs 0 next cycle.
REQ-043 SHALL check, with NOTCH_SWEEP_MIN_EN, point magnitudes 50,10,10,40 -> min_mag=10, min_idx=1.
